// File: rtl/mac_pkg.sv
// Shared types, defaults and fixed-point helpers for the dot-product MAC.
package mac_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_FRAC  = 20;
  localparam int DEF_LANES = 4;
  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  typedef logic signed [63:0] s64_t;

  function automatic s64_t rnd_shr(s64_t v, int frac);
    return (v + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

  function automatic s64_t lim_hi(int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic s64_t lim_lo(int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic sat_chk(s64_t v, int w);
    return (v > lim_hi(w)) || (v < lim_lo(w));
  endfunction

  function automatic s64_t sat_val(s64_t v, int w);
    if (v > lim_hi(w)) return lim_hi(w);
    if (v < lim_lo(w)) return lim_lo(w);
    return v;
  endfunction

endpackage

// File: rtl/mac_lane_mult.sv
// One multiplier lane: full-precision product, round half up,
// shift out the fraction, saturate, register.
module mac_lane_mult
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] m_i,
  output logic signed [WIDTH-1:0] p_o,
  output logic                    ovf_o
);

  logic signed [2*WIDTH-1:0] prod;
  s64_t                      rnd;
  logic signed [WIDTH-1:0]   p_d, p_q;
  logic                      ovf_d, ovf_q;

  always_comb begin
    prod  = x_i * m_i;
    rnd   = rnd_shr(s64_t'(prod), FRAC);
    p_d   = WIDTH'(sat_val(rnd, WIDTH));
    ovf_d = sat_chk(rnd, WIDTH);
  end

  // Non-accepted cycles load zero so bubbles add nothing downstream.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i || !en_i) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      ovf_q <= ovf_d;
    end
  end

  assign p_o   = p_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mac_dot.sv
// Pipelined signed fixed-point dot product: lane multipliers,
// saturating lane sum, saturating accumulator, control FSM.
module mac_dot
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int LANES = DEF_LANES,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [LEN_W-1:0]        i_len,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic [LANES*WIDTH-1:0]  i_x,
  input  logic [LANES*WIDTH-1:0]  i_m,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_mac,
  output logic                    o_ovf
);

  localparam int SW = WIDTH + $clog2(LANES);

  state_e                  state_q;
  logic [LEN_W-1:0]        len_q, cnt_q, cnt_d;
  logic                    fl_q;
  logic                    start_ok, accept;

  logic signed [WIDTH-1:0] p_w [LANES];
  logic [LANES-1:0]        povf_w;

  logic signed [SW-1:0]    sum_d;
  logic signed [WIDTH-1:0] s_d, s_q;
  logic signed [WIDTH-1:0] acc_d, acc_q;
  logic                    o2_d, o2_q;
  logic                    ovf_d, ovf_q;

  logic                    valid_q;
  logic signed [WIDTH-1:0] mac_q;
  logic                    movf_q;

  assign start_ok = (state_q == S_IDLE) && i_start && !i_clr;
  assign accept   = (state_q == S_RUN) && i_valid && !i_clr;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane_mult #(
      .WIDTH(WIDTH),
      .FRAC (FRAC)
    ) u_mult (
      .clk_i (clk),
      .rst_ni(rst),
      .clr_i (i_clr),
      .en_i  (accept),
      .x_i   (i_x[k*WIDTH +: WIDTH]),
      .m_i   (i_m[k*WIDTH +: WIDTH]),
      .p_o   (p_w[k]),
      .ovf_o (povf_w[k])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_d = sum_d + SW'(p_w[k]);
    end
    s_d   = WIDTH'(sat_val(s64_t'(sum_d), WIDTH));
    o2_d  = (|povf_w) | sat_chk(s64_t'(sum_d), WIDTH);
    acc_d = WIDTH'(sat_val(s64_t'(acc_q) + s64_t'(s_q), WIDTH));
    ovf_d = ovf_q | o2_q
          | sat_chk(s64_t'(acc_q) + s64_t'(s_q), WIDTH);
    cnt_d = cnt_q + LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      s_q   <= '0;
      o2_q  <= 1'b0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      o2_q <= o2_d;
      if (start_ok) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // The result is latched leaving DONE, once the last beat has
  // cleared the accumulator stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      fl_q    <= 1'b0;
      valid_q <= 1'b0;
      mac_q   <= '0;
      movf_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (i_clr) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (i_start) begin
              len_q   <= i_len;
              cnt_q   <= '0;
              state_q <= (i_len == '0) ? S_DONE : S_RUN;
            end
          end
          S_RUN: begin
            if (i_valid) begin
              cnt_q <= cnt_d;
              fl_q  <= 1'b0;
              if (cnt_d == len_q) state_q <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            fl_q <= 1'b1;
            if (fl_q) state_q <= S_DONE;
          end
          S_DONE: begin
            state_q <= S_IDLE;
            valid_q <= 1'b1;
            mac_q   <= acc_q;
            movf_q  <= ovf_q;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_ready = (state_q == S_RUN);
  assign o_busy  = (state_q != S_IDLE);
  assign o_valid = valid_q;
  assign o_mac   = mac_q;
  assign o_ovf   = movf_q;

endmodule

// File: doc/mac_dot.md
MAC_DOT -- requirements
Module: mac_dot

Interface
REQ-001 Parameter WIDTH, default 24: signed fixed-point word width of operands and result.
REQ-002 Parameter FRAC, default 20: fractional bits; 1.0 = 2^FRAC.
REQ-003 Parameter LANES, default 4: parallel multiplier lanes per beat, power of two, >= 1.
REQ-004 Parameter LEN_W, default 8: width of the vector-length field.
REQ-005 Port clk  in  1: single clock; all logic is on the rising edge.
REQ-006 Port rst  in  1: reset, synchronous, active-low.
REQ-007 Port i_start  in  1: starts a dot product of i_len beats; sampled only in IDLE.
REQ-008 Port i_len  in  LEN_W: number of beats; captured when i_start is accepted.
REQ-009 Port i_clr  in  1: synchronous abort; discards the operation in progress.
REQ-010 Port i_valid  in  1: i_x/i_m carry a beat.
REQ-011 Port i_x  in  LANES*WIDTH: packed signed operands; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-012 Port i_m  in  LANES*WIDTH: packed signed multiplicands, same packing as i_x.
REQ-013 Port o_ready  out  1: high only in RUN; a beat is accepted on a rising edge where i_valid and o_ready are both high.
REQ-014 Port o_busy  out  1: high in every state except IDLE.
REQ-015 Port o_valid  out  1: one-cycle pulse marking o_mac/o_ovf as the result.
REQ-016 Port o_mac  out  WIDTH: signed dot-product result; held until the next result or reset.
REQ-017 Port o_ovf  out  1: set if any saturation occurred during the operation; held with o_mac.

Function
REQ-018 States SHALL be IDLE, RUN, FLUSH and DONE.
REQ-019 IDLE -> RUN on i_start with i_len != 0; this clears the accumulator, the beat counter and the sticky overflow.
REQ-020 i_start with i_len == 0 SHALL go IDLE -> DONE, giving an o_valid pulse on the next cycle with o_mac = 0 and o_ovf = 0.
REQ-021 RUN: accepted beats are counted; on acceptance of beat i_len the state SHALL go to FLUSH. Cycles with i_valid low are stalls and SHALL NOT change the count.
REQ-022 FLUSH SHALL last 2 cycles for pipeline drain, then DONE; DONE lasts 1 cycle with o_valid high, then IDLE.
REQ-023 Latency: o_valid SHALL rise exactly 3 rising edges after the edge that accepts the last beat.
REQ-024 Stage 1 SHALL compute each lane product at full 2*WIDTH precision, add 2^(FRAC-1) (round half up), arithmetic-shift right by FRAC, saturate to WIDTH, and register the result.
REQ-025 Stage 2 SHALL sum the lanes at WIDTH+log2(LANES) bits, saturate to WIDTH, and register the result.
REQ-026 Stage 3 SHALL add the lane sum into a WIDTH accumulator with saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 Any saturation in stages 1-3 SHALL set the sticky overflow for the current operation.
REQ-028 Only accepted beats SHALL propagate; stall bubbles contribute 0.
REQ-029 i_start while o_busy is high SHALL be ignored.
REQ-030 i_clr SHALL return the block to IDLE on the next edge from any state, flush the pipeline and suppress o_valid; o_mac/o_ovf keep their previous values.
REQ-031 i_clr high on the same edge as i_start SHALL win: the block stays in IDLE.

Reset
REQ-032 With rst low at a rising edge, the block SHALL enter IDLE and zero all pipeline registers, the accumulator, the counter, o_mac, o_ovf and o_valid.
REQ-033 After reset, o_ready = 0 and o_busy = 0; reset mid-operation SHALL discard the operation without producing o_valid.

Structure
REQ-034 The state encoding, the rounding/saturation helper functions and the default parameter constants SHALL live in shared package mac_pkg.
REQ-035 The per-lane round/saturate multiplier SHALL be sub-module mac_lane_mult, instantiated LANES times; the adder tree and the FSM stay in mac_dot.

Verification (WIDTH=24, FRAC=20, LANES=4)
REQ-036 i_len=2, all lanes x=0x100000 (1.0), m=0x080000 (0.5), back-to-back -> o_valid 3 edges after last beat, o_mac=0x400000, o_ovf=0.
REQ-037 i_len=1, all lanes x=m=0x200000 (2.0) -> o_mac=0x7FFFFF, o_ovf=1; same with m=0xE00000 (-2.0) -> o_mac=0x800000, o_ovf=1.
REQ-038 Lane 0 x=0x000001, m=0x080000, other lanes 0 -> o_mac=0x000001 (rounded up); with m=0x07FFFF -> o_mac=0x000000.
REQ-039 i_len=3 with i_valid low for 2 cycles between beats -> count and result unaffected (each beat 1.0*1.0 on lane 0 -> o_mac=0x300000); o_valid 3 edges after third accept.
REQ-040 i_clr asserted in RUN after 1 of 4 beats -> IDLE next edge, no o_valid, o_mac unchanged; a following i_len=1 run gives a correct fresh result.
REQ-041 rst low during FLUSH -> no o_valid, all outputs 0; i_start with i_len=0 -> o_valid next cycle, o_mac=0.
